// File: rtl/lisnoc_router_output_pkg.sv
// lisnoc_router_output_pkg: flit type encodings, vchannel FSM states and pointer width helper.
package lisnoc_router_output_pkg;
  localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] TYPE_HEADER = 2'b01;
  localparam logic [1:0] TYPE_LAST = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;
  typedef enum logic {IDLE, LOCKED} vc_state_e;
  function automatic int ptr_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lisnoc_router_output_if.sv
// lisnoc_router_output_if: switch-side request/flit/read bundle and outgoing link of one router output.
interface lisnoc_router_output_if #(
  parameter int FW = 34,
  parameter int PORTS = 5,
  parameter int VCH = 1
);
  logic [VCH*PORTS-1:0] switch_request;
  logic [VCH*PORTS*FW-1:0] switch_flit;
  logic [VCH*PORTS-1:0] switch_read;
  logic [FW-1:0] link_flit;
  logic [VCH-1:0] link_valid;
  logic [VCH-1:0] link_ready;
  modport master (
    input switch_request, switch_flit, link_ready,
    output switch_read, link_flit, link_valid
  );
  modport slave (
    output switch_request, switch_flit, link_ready,
    input switch_read, link_flit, link_valid
  );
endinterface

// File: rtl/lisnoc_router_output_arb_rr.sv
// lisnoc_arb_rr: combinational round-robin arbiter, grants the first requester at or after ptr_i.
module lisnoc_arb_rr
  import lisnoc_router_output_pkg::*;
#(
  parameter int N = 5,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);
  // scanning from the farthest candidate lets the nearest requester overwrite the rest
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = PW'((int'(ptr_i) + i) % N);
      end
    end
  end
endmodule

// File: rtl/lisnoc_router_output.sv
// lisnoc_router_output: per-vchannel wormhole port arbitration into small FIFOs, round-robin link mux.
// Define LISNOC_OUTPUT_PROTO_CHECK_EN to add the sticky per-vchannel framing error output.
module lisnoc_router_output
  import lisnoc_router_output_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ports = 5,
  parameter int vchannels = 1,
  parameter int fifo_length = 4
) (
  input logic clk,
  input logic rst,
  lisnoc_router_output_if.master bus
`ifdef LISNOC_OUTPUT_PROTO_CHECK_EN
  ,
  output logic [vchannels-1:0] proto_error_o
`endif
);
  localparam int FW = flit_data_width + flit_type_width;
  localparam int PPW = ptr_width(ports);
  localparam int VPW = ptr_width(vchannels);
  localparam int FPW = $clog2(fifo_length);
  localparam int CW = FPW + 1;
  localparam logic [flit_type_width-1:0] T_HEADER = flit_type_width'(TYPE_HEADER);
  localparam logic [flit_type_width-1:0] T_PAYLOAD = flit_type_width'(TYPE_PAYLOAD);
  localparam logic [flit_type_width-1:0] T_LAST = flit_type_width'(TYPE_LAST);
  localparam logic [flit_type_width-1:0] T_SINGLE = flit_type_width'(TYPE_SINGLE);

  logic [FW-1:0] head [vchannels];
  logic [vchannels-1:0] nonempty;
  logic [vchannels-1:0] pop;

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    vc_state_e state_q, state_d;
    logic [PPW-1:0] ptr_q, ptr_d, owner_q, owner_d, gidx;
    logic [ports-1:0] req, req_m, gnt, rd;
    logic [FW-1:0] mem_q [fifo_length];
    logic [FPW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [FW-1:0] flit;
    logic [flit_type_width-1:0] ftype;
    logic push;
    assign req = bus.switch_request[v*ports +: ports];
    // a locked vchannel only lets its owner through the arbiter
    assign req_m = state_q == LOCKED ? req & (ports'(1) << owner_q) : req;
    lisnoc_arb_rr #(.N(ports)) u_arb (
      .req_i(req_m),
      .ptr_i(ptr_q),
      .gnt_o(gnt),
      .idx_o(gidx)
    );
    assign flit = bus.switch_flit[(v*ports + int'(gidx))*FW +: FW];
    assign ftype = flit[FW-1 -: flit_type_width];
    always_comb rd = (!rst && cnt_q < CW'(fifo_length)) ? gnt : '0;
    assign push = |rd;
    assign bus.switch_read[v*ports +: ports] = rd;
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d = ptr_q;
      if (push && state_q == IDLE) begin
        ptr_d = gidx == PPW'(ports - 1) ? '0 : gidx + 1'b1;
        state_d = ftype == T_HEADER ? LOCKED : IDLE;
        owner_d = ftype == T_HEADER ? gidx : owner_q;
      end else if (push && ftype == T_LAST) begin
        state_d = IDLE;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q <= ptr_d;
      end
    end
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= flit;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
        cnt_q <= '0;
      end else begin
        wr_q <= wr_q + FPW'(push);
        rd_q <= rd_q + FPW'(pop[v]);
        cnt_q <= cnt_q + CW'(push) - CW'(pop[v]);
      end
    end
    assign head[v] = mem_q[rd_q];
    assign nonempty[v] = cnt_q != '0;
`ifdef LISNOC_OUTPUT_PROTO_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else err_q <= err_q | (push && (state_q == LOCKED ? (ftype == T_HEADER || ftype == T_SINGLE)
                                                         : (ftype == T_PAYLOAD || ftype == T_LAST)));
    end
    assign proto_error_o[v] = err_q;
`endif
  end

  logic [vchannels-1:0] elig, lgnt;
  logic [VPW-1:0] lptr_q, lidx;
  logic [FW-1:0] last_q;
  assign elig = nonempty & bus.link_ready & {vchannels{!rst}};
  lisnoc_arb_rr #(.N(vchannels)) u_link_arb (
    .req_i(elig),
    .ptr_i(lptr_q),
    .gnt_o(lgnt),
    .idx_o(lidx)
  );
  assign pop = lgnt;
  assign bus.link_valid = lgnt;
  // an idle link keeps presenting the last flit it carried
  assign bus.link_flit = |lgnt ? head[lidx] : last_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      lptr_q <= '0;
      last_q <= '0;
    end else begin
      last_q <= bus.link_flit;
      if (|lgnt) lptr_q <= lidx == VPW'(vchannels - 1) ? '0 : lidx + 1'b1;
    end
  end
endmodule

// File: tb/tb_lisnoc_router_output.sv
// tb_lisnoc_router_output: scoreboard bench, upstream port queues feed the switch, link output is checked in order.
module tb_lisnoc_router_output;
  import lisnoc_router_output_pkg::*;
  localparam int DW = 32, TW = 2, FW = 34, P = 5, V = 2, FL = 4, N = P * V;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lisnoc_router_output_if #(.FW(FW), .PORTS(P), .VCH(V)) bus ();
`ifdef LISNOC_OUTPUT_PROTO_CHECK_EN
  logic [V-1:0] proto_error;
`endif

  lisnoc_router_output #(
    .flit_data_width(DW),
    .flit_type_width(TW),
    .ports(P),
    .vchannels(V),
    .fifo_length(FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
`ifdef LISNOC_OUTPUT_PROTO_CHECK_EN
    ,
    .proto_error_o(proto_error)
`endif
  );

  logic [FW-1:0] pq [N][$];
  logic [FW-1:0] exp_q [V][$];
  logic [N-1:0] rd_s = '0;
  int rdcnt [N];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.switch_request[i] = pq[i].size() > 0;
      bus.switch_flit[i*FW +: FW] = pq[i].size() > 0 ? pq[i][0] : '0;
    end
  endtask

  task automatic send(int port, int vc, logic [1:0] t, logic [31:0] d);
    pq[vc*P + port].push_back({t, d});
    exp_q[vc].push_back({t, d});
  endtask

  task automatic pstep();
    @(posedge clk);
    #2;
  endtask

  task automatic nwait(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int left();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    for (int v = 0; v < V; v++) s += exp_q[v].size();
    return s;
  endfunction

  task automatic wait_drain(string tag, int max);
    for (int c = 0; c < max && left() != 0; c++) nwait(1);
    chk(tag, 64'(left()), 0);
  endtask

  task automatic do_reset();
    pstep();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      rdcnt[i] = 0;
    end
    for (int v = 0; v < V; v++) exp_q[v].delete();
    drive();
    pstep();
    pstep();
    rst = 1'b0;
    nwait(1);
  endtask

  // monitor: records switch reads and checks link flits against the scoreboard
  initial forever begin
    @(negedge clk);
    rd_s = bus.switch_read;
    for (int i = 0; i < N; i++) rdcnt[i] += int'(rd_s[i]);
    for (int v = 0; v < V; v++) begin
      if (bus.link_valid[v]) begin
        if (exp_q[v].size() == 0) chk($sformatf("link_extra_vc%0d", v), 64'(exp_q[v].size()), 1);
        else chk($sformatf("link_vc%0d", v), 64'(bus.link_flit), 64'(exp_q[v].pop_front()));
      end
    end
  end

  // upstream ports: pop the flit the router read at the previous edge
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rd_s[i] && pq[i].size() > 0) pq[i].delete(0);
    drive();
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.link_ready = '1;
    drive();
    do_reset();
    chk("rst_read", 64'(bus.switch_read), 0);
    chk("rst_valid", 64'(bus.link_valid), 0);
    chk("rst_flit", 64'(bus.link_flit), 0);
`ifdef LISNOC_OUTPUT_PROTO_CHECK_EN
    chk("rst_proto", 64'(proto_error), 0);
`endif
    // single flit from port 2, then pointer must sit at 3
    pstep();
    send(2, 0, TYPE_SINGLE, 32'h0000_00AA);
    drive();
    nwait(1);
    chk("t1_read", 64'(bus.switch_read), 64'h004);
    nwait(1);
    chk("t1_read_drop", 64'(bus.switch_read), 0);
    chk("t1_valid", 64'(bus.link_valid), 2'b01);
    pstep();
    send(3, 0, TYPE_SINGLE, 32'h33);
    send(2, 0, TYPE_SINGLE, 32'h22);
    drive();
    wait_drain("t1_ptr_drain", 20);
    // two 3-flit packets, no interleaving
    do_reset();
    pstep();
    send(0, 0, TYPE_HEADER, 32'h100);
    send(0, 0, TYPE_PAYLOAD, 32'h101);
    send(0, 0, TYPE_LAST, 32'h102);
    send(3, 0, TYPE_HEADER, 32'h300);
    send(3, 0, TYPE_PAYLOAD, 32'h301);
    send(3, 0, TYPE_LAST, 32'h302);
    drive();
    wait_drain("t2_drain", 40);
`ifdef LISNOC_OUTPUT_PROTO_CHECK_EN
    chk("t2_proto_clean", 64'(proto_error), 0);
`endif
    // backpressure: 6-flit packet against a 4-deep FIFO
    do_reset();
    pstep();
    bus.link_ready[0] = 1'b0;
    for (int k = 0; k < 6; k++)
      send(1, 0, k == 0 ? TYPE_HEADER : k == 5 ? TYPE_LAST : TYPE_PAYLOAD, 32'h600 + k);
    drive();
    nwait(10);
    chk("t3_reads", 64'(rdcnt[1]), 4);
    chk("t3_stall", 64'(bus.switch_read), 0);
    chk("t3_valid_stall", 64'(bus.link_valid), 0);
    pstep();
    bus.link_ready[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nwait(1);
      chk($sformatf("t3_flow%0d", k), 64'(bus.link_valid), 2'b01);
    end
    wait_drain("t3_drain", 10);
    // vc1 stalled must not block vc0, then fair alternation
    do_reset();
    pstep();
    bus.link_ready = 2'b01;
    send(0, 1, TYPE_SINGLE, 32'hB0);
    send(0, 1, TYPE_SINGLE, 32'hB1);
    send(2, 0, TYPE_HEADER, 32'hA0);
    send(2, 0, TYPE_PAYLOAD, 32'hA1);
    send(2, 0, TYPE_LAST, 32'hA2);
    drive();
    for (int c = 0; c < 8 && exp_q[0].size() != 0; c++) nwait(1);
    chk("t4_vc0_flow", 64'(exp_q[0].size()), 0);
    chk("t4_vc1_held", 64'(exp_q[1].size()), 2);
    pstep();
    bus.link_ready = 2'b00;
    send(0, 0, TYPE_SINGLE, 32'hC0);
    send(0, 0, TYPE_SINGLE, 32'hC1);
    send(0, 0, TYPE_SINGLE, 32'hC2);
    send(4, 1, TYPE_SINGLE, 32'hD0);
    drive();
    nwait(6);
    pstep();
    bus.link_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      nwait(1);
      chk($sformatf("t4_alt%0d", k), 64'(bus.link_valid), k % 2 ? 2'b01 : 2'b10);
    end
    wait_drain("t4_drain", 10);
    // reset in the middle of a locked packet
    do_reset();
    pstep();
    bus.link_ready = 2'b00;
    send(1, 0, TYPE_HEADER, 32'h510);
    send(1, 0, TYPE_PAYLOAD, 32'h511);
    drive();
    nwait(4);
    pstep();
    rst = 1'b1;
    bus.link_ready = 2'b11;
    pq[P + 1].delete();
    pq[1].delete();
    exp_q[0].delete();
    drive();
    pstep();
    rst = 1'b0;
    nwait(1);
    chk("t5_valid", 64'(bus.link_valid), 0);
    chk("t5_read", 64'(bus.switch_read), 0);
    pstep();
    send(4, 0, TYPE_HEADER, 32'h540);
    send(4, 0, TYPE_LAST, 32'h541);
    drive();
    nwait(1);
    chk("t5_grant", 64'(bus.switch_read), 64'h010);
    wait_drain("t5_drain", 20);
`ifdef LISNOC_OUTPUT_PROTO_CHECK_EN
    // stray PAYLOAD while idle flags vc0 and the flag sticks until reset
    do_reset();
    pstep();
    send(0, 0, TYPE_PAYLOAD, 32'h700);
    drive();
    nwait(1);
    chk("t6_pre", 64'(proto_error), 0);
    nwait(1);
    chk("t6_set", 64'(proto_error), 2'b01);
    pstep();
    send(0, 0, TYPE_SINGLE, 32'h701);
    drive();
    nwait(5);
    chk("t6_sticky", 64'(proto_error), 2'b01);
    wait_drain("t6_drain", 10);
    do_reset();
    chk("t6_clear", 64'(proto_error), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
